// File: rtl/ram_access_unit_if.sv
// RAM request/ack bus between ram_access_unit (master) and the data RAM (slave).
interface ram_access_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_access_unit.sv
// Executes READ_RAM / WRITE_RAM opcodes against the data RAM and writes loads back to the register file.
// Optional REQ timeout abort is enabled by defining RAM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a READ_RAM / WRITE_RAM opcode strobe
// REQ   | mem.req held, waiting for mem.ack
// WB    | load word presented to the register file with a 1-cycle write pulse
// DONE  | 1-cycle done (and err on timeout), then back to IDLE
module ram_access_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           opcode,
  input  logic                  op_valid,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  ram_access_unit_if.master     mem
);

  localparam logic [7:0] OP_READ_RAM  = 8'h92;
  localparam logic [7:0] OP_WRITE_RAM = 8'h91;

  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;
  state_t state;

  logic is_read;
  logic is_write;
  assign is_read  = (opcode[15:8] == OP_READ_RAM);
  assign is_write = (opcode[15:8] == OP_WRITE_RAM);

  // Only the operator byte and the low address bits matter; the rest of the opcode is don't-care here.
  logic opcode_unused;
  assign opcode_unused = ^opcode;

`ifdef RAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] req_cnt;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem.req          <= 1'b0;
      mem.we           <= 1'b0;
      mem.addr         <= '0;
      mem.wdata        <= '0;
      reg_write_data   <= '0;
      reg_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
`ifdef RAM_TIMEOUT_EN
      req_cnt          <= '0;
`endif
    end else begin
      reg_write_enable <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && (is_read || is_write)) begin
            mem.addr <= opcode[ADDR_WIDTH-1:0];
            mem.we   <= is_write;
            if (is_write) mem.wdata <= reg_read_data;
            mem.req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
`ifdef RAM_TIMEOUT_EN
            req_cnt  <= '0;
`endif
          end
        end
        REQ: begin
          // An ack on the terminal timeout cycle still completes the access normally.
          if (mem.ack) begin
            mem.req <= 1'b0;
            if (mem.we) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              reg_write_data   <= mem.rdata;
              reg_write_enable <= 1'b1;
              state            <= WB;
            end
          end
`ifdef RAM_TIMEOUT_EN
          else if (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem.req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Scoreboard bench for ram_access_unit: stimulus pushes expected RAM requests, writebacks and completions;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_access_unit;
  localparam int DW = 16;
  localparam int AW = 8;
`ifdef RAM_TIMEOUT_EN
  localparam int TMO   = 8;
  localparam int STALL = 3;
`else
  localparam int TMO   = 64;
  localparam int STALL = 20;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   opcode = '0;
  logic          op_valid = 1'b0;
  logic [DW-1:0] reg_read_data = '0;
  logic [DW-1:0] reg_write_data;
  logic          reg_write_enable, busy, done, err;

  ram_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

  ram_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op_valid(op_valid),
    .reg_read_data(reg_read_data), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .busy(busy), .done(done), .err(err),
    .mem(mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  mem_exp_t      exp_mem[$];
  logic [DW-1:0] exp_wb[$];
  logic          exp_done[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // RAM model: acks after ack_delay REQ cycles (-1 = never); stray_ack pulses ack outside REQ.
  logic [DW-1:0] ram [0:255];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic stray_ack = 1'b0;

  always @(negedge clk) begin
    mem_bus.ack = 1'b0;
    if (mem_bus.req) begin
      if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = ram[mem_bus.addr];
        if (mem_bus.we) ram[mem_bus.addr] = mem_bus.wdata;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (stray_ack) begin
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 16'hDEAD;
      end
    end
  end

  logic     prev_req = 1'b0;
  mem_exp_t e_mem;
  logic [DW-1:0] e_wb;
  logic     e_done;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_bus.req && !prev_req) begin
        if (exp_mem.size() == 0) check("unexpected_mem_req", 32'(mem_bus.addr), 32'hFFFF_FFFF);
        else begin
          e_mem = exp_mem.pop_front();
          check("mem_addr", 32'(mem_bus.addr), 32'(e_mem.addr));
          check("mem_we", 32'(mem_bus.we), 32'(e_mem.we));
          if (e_mem.we) check("mem_wdata", 32'(mem_bus.wdata), 32'(e_mem.wdata));
        end
      end
      if (reg_write_enable) begin
        if (exp_wb.size() == 0) check("unexpected_writeback", 32'(reg_write_data), 32'hFFFF_FFFF);
        else begin
          e_wb = exp_wb.pop_front();
          check("reg_write_data", 32'(reg_write_data), 32'(e_wb));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 32'(err), 32'hFFFF_FFFF);
        else begin
          e_done = exp_done.pop_front();
          check("done_err", 32'(err), 32'(e_done));
        end
      end
      if (err && !done) check("err_without_done", 32'(done), 32'd1);
    end
    prev_req = mem_bus.req;
  end

  task automatic issue(input logic [15:0] op, input logic [DW-1:0] rd);
    @(negedge clk);
    opcode        = op;
    reg_read_data = rd;
    op_valid      = 1'b1;
    @(negedge clk);
    op_valid      = 1'b0;
  endtask

  // Edges from the accepting edge (counted as 1) to the edge that returns the unit to IDLE.
  task automatic wait_idle(output int edges);
    edges = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    for (int i = 0; i < 256; i++) ram[i] = 16'(16'h0100 + i);
    ram[5] = 16'hBEEF;
    ram[6] = 16'h6666;
    ram[7] = 16'h7777;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_bus.req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wr_en", 32'(reg_write_enable), 0);
    check("rst_wr_data", 32'(reg_write_data), 0);
    check("rst_mem_addr", 32'(mem_bus.addr), 0);
    check("rst_mem_we", 32'(mem_bus.we), 0);
    check("rst_mem_wdata", 32'(mem_bus.wdata), 0);
    reset = 1'b0;

    // Read with ack after 3 waiting cycles
    ack_delay = 3;
    exp_mem.push_back('{addr: 8'h05, we: 1'b0, wdata: '0});
    exp_wb.push_back(16'hBEEF);
    exp_done.push_back(1'b0);
    issue(16'h9205, 16'h0000);
    wait_idle(edges);
    check("read_latency_ack3", 32'(edges), 7);
    check("load_held", 32'(reg_write_data), 32'h0000BEEF);

    // Write: store data captured at accept, then changed
    ack_delay = 1;
    exp_mem.push_back('{addr: 8'h10, we: 1'b1, wdata: 16'h1234});
    exp_done.push_back(1'b0);
    issue(16'h9110, 16'h1234);
    reg_read_data = 16'hFFFF;
    wait_idle(edges);
    check("write_latency_ack1", 32'(edges), 4);
    check("ram_10_written", 32'(ram[8'h10]), 32'h00001234);
    check("load_held_after_write", 32'(reg_write_data), 32'h0000BEEF);

    // Non-RAM opcodes and stray ack in IDLE are ignored
    issue(16'h2203, 16'h0000);
    issue(16'h1A00, 16'h0000);
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("ignored_busy", 32'(busy), 0);
    check("ignored_mem_req", 32'(mem_bus.req), 0);
    check("ignored_wr_data", 32'(reg_write_data), 32'h0000BEEF);

    // op_valid while busy is dropped
    ack_delay = 3;
    exp_mem.push_back('{addr: 8'h06, we: 1'b0, wdata: '0});
    exp_wb.push_back(16'h6666);
    exp_done.push_back(1'b0);
    issue(16'h9206, 16'h0000);
    issue(16'h9201, 16'h0000);
    wait_idle(edges);
    repeat (3) @(negedge clk);
    check("busy_op_addr", 32'(mem_bus.addr), 32'h06);
    check("busy_op_idle", 32'(busy), 0);

    // Back-to-back, ack in first REQ cycle
    ack_delay = 0;
    exp_mem.push_back('{addr: 8'h07, we: 1'b0, wdata: '0});
    exp_wb.push_back(16'h7777);
    exp_done.push_back(1'b0);
    exp_mem.push_back('{addr: 8'h20, we: 1'b1, wdata: 16'h5A5A});
    exp_done.push_back(1'b0);
    issue(16'h9207, 16'h0000);
    wait_idle(edges);
    check("read_min_latency", 32'(edges), 4);
    issue(16'h9120, 16'h5A5A);
    wait_idle(edges);
    check("write_min_latency", 32'(edges), 3);
    check("ram_20_written", 32'(ram[8'h20]), 32'h00005A5A);

    // Stalled read, then reset mid-REQ
    ack_delay = -1;
    exp_mem.push_back('{addr: 8'h05, we: 1'b0, wdata: '0});
    issue(16'h9205, 16'h0000);
    repeat (STALL) @(negedge clk);
    check("stall_busy", 32'(busy), 1);
    check("stall_mem_req", 32'(mem_bus.req), 1);
    check("stall_err", 32'(err), 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_mem_req", 32'(mem_bus.req), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wr_en", 32'(reg_write_enable), 0);
    check("midrst_done", 32'(done), 0);
    ack_delay = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_busy", 32'(busy), 0);

`ifdef RAM_TIMEOUT_EN
    ack_delay = -1;
    exp_mem.push_back('{addr: 8'h08, we: 1'b0, wdata: '0});
    exp_done.push_back(1'b1);
    issue(16'h9208, 16'h0000);
    wait_idle(edges);
    check("timeout_latency", 32'(edges), 10);
    check("timeout_no_load", 32'(reg_write_data), 0);
    ack_delay = 0;
`endif

    repeat (3) @(negedge clk);
    check("pending_mem", 32'(exp_mem.size()), 0);
    check("pending_wb", 32'(exp_wb.size()), 0);
    check("pending_done", 32'(exp_done.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
